// File: rtl/winograd_pkg.sv
// +----------------------------------------------------------------------+
// | winograd_pkg: shared types for the Winograd RTU scheduler            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package winograd_pkg;

    localparam int DATA_W = 16;

    typedef logic [5:0][5:0][DATA_W-1:0] tile6_t;
    typedef logic [3:0][3:0][DATA_W-1:0] tile4_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/winograd_rtu_scheduler_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick starting at pointer       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] pointer,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 any_req
);

    int w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        w_idx     = 0;
        // Walk upward from the pointer, wrapping, and stop at the first requester
        for (int i = 0; i < N; i++) begin
            w_idx = int'(pointer) + i;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!any_req && req[w_idx]) begin
                any_req          = 1'b1;
                grant[w_idx]     = 1'b1;
                grant_idx        = w_idx[$clog2(N)-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/winograd_rtu_scheduler.sv
// +----------------------------------------------------------------------+
// | winograd_rtu_scheduler: shares one 6x6->4x4 output-transform unit    |
// | between N_REQ requesters with watchdog and status. Revision: 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module winograd_rtu_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = winograd_pkg::DATA_W,
    parameter int TIMEOUT = 15
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req,
    input  logic [N_REQ-1:0][5:0][5:0][DATA_W-1:0] req_tile,
    output logic [N_REQ-1:0]                     ack,
    output logic                                 rtu_start,
    output logic [5:0][5:0][DATA_W-1:0]          rtu_matrix_in,
    input  logic [3:0][3:0][DATA_W-1:0]          rtu_matrix_out,
    input  logic                                 rtu_done,
    output logic                                 resp_valid,
    input  logic                                 resp_ready,
    output logic [$clog2(N_REQ)-1:0]             resp_id,
    output logic [3:0][3:0][DATA_W-1:0]          resp_tile,
    output logic                                 busy,
    output logic [15:0]                          tile_count,
    output logic                                 err_timeout,
    output logic [$clog2(N_REQ)-1:0]             err_id
);

    import winograd_pkg::*;

    localparam int c_id_w = $clog2(N_REQ);
    localparam int c_wd_w = $clog2(TIMEOUT + 1) + 1;

    sched_state_t                   r_state;
    logic [5:0][5:0][DATA_W-1:0]    r_tile;
    logic [c_id_w-1:0]              r_ptr;
    logic [c_id_w-1:0]              r_id;
    logic [c_wd_w-1:0]              r_wd;

    logic [N_REQ-1:0]               w_grant;
    logic [c_id_w-1:0]              w_grant_idx;
    logic                           w_any_req;
    logic [c_id_w-1:0]              w_ptr_next;
    logic [c_wd_w-1:0]              w_wd_next;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req       (req),
        .pointer   (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_req   (w_any_req)
    );

    assign w_ptr_next    = (w_grant_idx == c_id_w'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_wd_next     = r_wd + 1'b1;
    assign rtu_matrix_in = r_tile;
    assign busy          = (r_state != IDLE);
    assign resp_id       = r_id;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tile      <= '0;
            r_ptr       <= '0;
            r_id        <= '0;
            r_wd        <= '0;
            ack         <= '0;
            rtu_start   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_tile   <= '0;
            tile_count  <= '0;
            err_timeout <= 1'b0;
            err_id      <= '0;
        end else begin
            ack       <= '0;
            rtu_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_tile    <= req_tile[w_grant_idx];
                        ack       <= w_grant;
                        r_id      <= w_grant_idx;
                        r_ptr     <= w_ptr_next;
                        rtu_start <= 1'b1;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Watchdog counts cycles elapsed since the start pulse
                    r_wd    <= c_wd_w'(1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (rtu_done) begin
                        resp_tile  <= rtu_matrix_out;
                        resp_valid <= 1'b1;
                        r_state    <= RESP;
                    end else if (w_wd_next == c_wd_w'(TIMEOUT)) begin
                        err_timeout <= 1'b1;
                        err_id      <= r_id;
                        r_state     <= IDLE;
                    end else begin
                        r_wd <= w_wd_next;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        tile_count <= tile_count + 16'd1;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_winograd_rtu_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_winograd_rtu_scheduler: directed bench with a behavioural RTU     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_winograd_rtu_scheduler;

    import winograd_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [3:0]                req;
    logic [3:0][5:0][5:0][15:0] req_tile;
    logic [3:0]                ack;
    logic                      rtu_start;
    tile6_t                    rtu_matrix_in;
    tile4_t                    rtu_matrix_out;
    logic                      model_done;
    logic                      stray_done;
    logic                      rtu_done;
    logic                      resp_valid;
    logic                      resp_ready;
    logic [1:0]                resp_id;
    tile4_t                    resp_tile;
    logic                      busy;
    logic [15:0]               tile_count;
    logic                      err_timeout;
    logic [1:0]                err_id;

    int n_vec = 0;
    int n_err = 0;
    int rtu_lat;
    int cnt;

    always #5 clk = ~clk;
    assign rtu_done = model_done | stray_done;

    winograd_rtu_scheduler #(
        .N_REQ   (4),
        .DATA_W  (16),
        .TIMEOUT (15)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_tile       (req_tile),
        .ack            (ack),
        .rtu_start      (rtu_start),
        .rtu_matrix_in  (rtu_matrix_in),
        .rtu_matrix_out (rtu_matrix_out),
        .rtu_done       (rtu_done),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_id        (resp_id),
        .resp_tile      (resp_tile),
        .busy           (busy),
        .tile_count     (tile_count),
        .err_timeout    (err_timeout),
        .err_id         (err_id)
    );

    // Golden F(4x4,3x3) output transform Y = A^T * M * A
    function automatic tile4_t wino(input tile6_t m);
        int at [4][6];
        int t  [4][6];
        int acc;
        tile4_t y;
        at = '{'{1, 1,  1, 1,  1, 0},
               '{0, 1, -1, 2, -2, 0},
               '{0, 1,  1, 4,  4, 0},
               '{0, 1, -1, 8, -8, 1}};
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 6; k++) begin
                t[i][k] = 0;
                for (int r = 0; r < 6; r++) begin
                    t[i][k] += at[i][r] * int'($signed(m[r][k]));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 6; k++) begin
                    acc += t[i][k] * at[j][k];
                end
                y[i][j] = 16'(acc);
            end
        end
        return y;
    endfunction

    function automatic tile6_t mk_tile(input int base);
        tile6_t t;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                t[r][c] = 16'(base + r * 6 + c);
            end
        end
        return t;
    endfunction

    // Behavioural RTU: done pulses rtu_lat cycles after the start cycle; 0 = never
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= 0;
            model_done     <= 1'b0;
            rtu_matrix_out <= '0;
        end else begin
            model_done <= 1'b0;
            if (rtu_start && rtu_lat > 1) begin
                cnt <= rtu_lat - 1;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    model_done     <= 1'b1;
                    rtu_matrix_out <= wino(rtu_matrix_in);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        resp_ready = 1'b1;
        stray_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int order [6];
        int grants [6];
        int n_ack;
        int n_resp;
        int idx;
        int tc;

        rst        = 1'b1;
        req        = '0;
        resp_ready = 1'b1;
        stray_done = 1'b0;
        rtu_lat    = 4;
        req_tile   = '0;
        order      = '{0, 1, 2, 3, 0, 1};
        do_reset();

        check("rst_busy",  busy, 0);
        check("rst_ack",   ack, 0);
        check("rst_start", rtu_start, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_count", tile_count, 0);
        check("rst_err",   err_timeout, 0);

        // Single request, tile[r][c] = r*6+c
        req_tile[2] = mk_tile(0);
        req = 4'b0100;
        tick();
        check("t1_ack",   ack, 4'b0100);
        check("t1_start", rtu_start, 1);
        req = '0;
        repeat (4) tick();
        check("t1_early_valid", resp_valid, 0);
        tick();
        check("t1_valid", resp_valid, 1);
        check("t1_id",    resp_id, 2);
        check("t1_tile",  resp_tile, wino(mk_tile(0)));
        tick();
        check("t1_count", tile_count, 1);
        check("t1_idle",  busy, 0);

        // All requesters constant, round-robin order
        do_reset();
        rtu_lat = 2;
        for (int g = 0; g < 4; g++) req_tile[g] = mk_tile(g * 100);
        req_tile[3] = mk_tile(-500);
        req    = 4'hF;
        n_ack  = 0;
        n_resp = 0;
        for (int c = 0; c < 300 && n_resp < 6; c++) begin
            tick();
            if (ack != 4'b0000) begin
                check("t2_onehot", $onehot(ack), 1);
                idx = 0;
                for (int b = 0; b < 4; b++) if (ack[b]) idx = b;
                if (n_ack < 6) grants[n_ack] = idx;
                n_ack++;
                if (n_ack == 6) req = '0;
            end
            if (resp_valid && n_resp < 6) begin
                check("t2_id",   resp_id, order[n_resp]);
                check("t2_tile", resp_tile, wino(req_tile[order[n_resp]]));
                n_resp++;
            end
        end
        check("t2_nresp", n_resp, 6);
        check("t2_nack",  n_ack, 6);
        for (int i = 0; i < 6; i++) check("t2_order", grants[i], order[i]);
        tick();
        check("t2_count", tile_count, 6);

        // Backpressure with a waiting requester
        do_reset();
        rtu_lat    = 4;
        resp_ready = 1'b0;
        req        = 4'b0001;
        tick();
        check("t3_ack0", ack, 4'b0001);
        req = 4'b0010;
        for (int c = 0; c < 20 && !resp_valid; c++) tick();
        check("t3_valid", resp_valid, 1);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", resp_valid, 1);
            check("t3_hold_id",    resp_id, 0);
            check("t3_hold_tile",  resp_tile, wino(req_tile[0]));
            check("t3_hold_busy",  busy, 1);
            check("t3_hold_ack",   ack, 0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        check("t3_drop_valid", resp_valid, 0);
        check("t3_drop_ack",   ack, 0);
        check("t3_count1",     tile_count, 1);
        tick();
        check("t3_ack1", ack, 4'b0010);
        req = '0;
        for (int c = 0; c < 30 && tile_count != 16'd2; c++) tick();
        check("t3_count2", tile_count, 2);

        // Done on the last cycle before the watchdog fires counts as done
        do_reset();
        rtu_lat = 14;
        req = 4'b0100;
        tick();
        req = '0;
        repeat (14) tick();
        check("t4_edge_pre", resp_valid, 0);
        tick();
        check("t4_edge_valid", resp_valid, 1);
        check("t4_edge_err",   err_timeout, 0);
        tick();

        // Watchdog timeout on requester 3
        rtu_lat = 0;
        req = 4'b1000;
        tick();
        check("t5_ack", ack, 4'b1000);
        req = '0;
        repeat (14) tick();
        check("t5_pre_err",  err_timeout, 0);
        check("t5_pre_busy", busy, 1);
        tick();
        check("t5_err",    err_timeout, 1);
        check("t5_err_id", err_id, 3);
        check("t5_busy",   busy, 0);
        check("t5_valid",  resp_valid, 0);
        rtu_lat = 4;
        req = 4'b0001;
        tick();
        check("t5b_ack", ack, 4'b0001);
        req = '0;
        repeat (5) tick();
        check("t5b_valid", resp_valid, 1);
        check("t5b_id",    resp_id, 0);
        check("t5b_tile",  resp_tile, wino(req_tile[0]));
        check("t5b_err",   err_timeout, 1);
        tick();
        check("t5b_count", tile_count, 2);

        // Asynchronous reset in the middle of WAIT
        req = 4'b0010;
        tick();
        req = '0;
        repeat (2) tick();
        check("t6_pre_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_busy",  busy, 0);
        check("t6_valid", resp_valid, 0);
        check("t6_ack",   ack, 0);
        check("t6_count", tile_count, 0);
        check("t6_err",   err_timeout, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        req = 4'b0100;
        tick();
        check("t6_ack2",   ack, 4'b0100);
        check("t6_start2", rtu_start, 1);
        req = '0;
        repeat (5) tick();
        check("t6_valid2", resp_valid, 1);
        check("t6_id2",    resp_id, 2);
        check("t6_tile2",  resp_tile, wino(req_tile[2]));
        tick();

        // Stray done in IDLE and in ISSUE must be ignored
        tc = int'(tile_count);
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        check("t7_idle_busy", busy, 0);
        tick();
        check("t7_idle_valid", resp_valid, 0);
        check("t7_idle_start", rtu_start, 0);
        check("t7_idle_count", tile_count, tc);
        rtu_lat = 0;
        req = 4'b0001;
        tick();
        req = '0;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        tick();
        check("t7_issue_valid", resp_valid, 0);
        for (int c = 0; c < 40 && busy; c++) tick();
        check("t7_issue_idle",  busy, 0);
        check("t7_issue_err",   err_timeout, 1);
        check("t7_issue_count", tile_count, tc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
